// File: rtl/tap_pkg.sv
// Definitions shared by the JTAG USER-DR blocks (tap_decoder, tap_encoder):
// the TAP strobe bundle and a counter sizing helper.
package tap_pkg;

    typedef struct packed {
        logic test_logic_reset;
        logic ir_is_user;
        logic capture_dr;
        logic shift_dr;
        logic update_dr;
    } tap_strobe_t;

    // Bits needed to count 0..data_width shifted bits inclusive.
    function automatic int bit_count_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/tap_rx_fifo.sv
// Small word FIFO with registered data/valid head. A push into a full FIFO
// succeeds only when the head is popped in the same cycle.
module tap_rx_fifo
    import tap_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  tck,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr, rd_ptr_next;
    logic [CW-1:0]         count, count_next;
    logic                  pop, do_push, head_is_new;
    logic [DATA_WIDTH-1:0] head_next;

    assign pop     = valid & ready;
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_push = push & (~full | pop);

    // The pushed word becomes the head when nothing older survives this cycle.
    assign head_is_new = (count == CW'(0)) || (pop && count == CW'(1));
    assign rd_ptr_next = pop ? rd_ptr + PW'(1) : rd_ptr;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_next = count;
        head_next  = mem[rd_ptr_next];
        case ({do_push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
        if (head_is_new) head_next = push_data;
    end

    // NOTE: storage array carries no reset; only pointers/count/head decide what is visible.
    always_ff @(posedge tck) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            data   <= '0;
            valid  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            valid  <= (count_next != CW'(0));
            if (count_next != CW'(0)) data <= head_next;
        end
    end

endmodule

// File: rtl/tap_decoder.sv
// JTAG USER-DR receiver: deserialises TDI LSB-first during Shift-DR and
// commits each complete word into tap_rx_fifo on Update-DR.
module tap_decoder
    import tap_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  tck,
    input  logic                  reset,
    input  logic                  tdi,
    input  logic                  test_logic_reset,
    input  logic                  ir_is_user,
    input  logic                  capture_dr,
    input  logic                  shift_dr,
    input  logic                  update_dr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  overflow,
    output logic                  short_frame
);

    localparam int CW = bit_count_width(DATA_WIDTH);

    tap_strobe_t           strb;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         bit_count;
    logic                  frame_full, update_ok, push, fifo_full;

    assign strb = '{test_logic_reset: test_logic_reset, ir_is_user: ir_is_user,
                    capture_dr: capture_dr, shift_dr: shift_dr, update_dr: update_dr};

    assign frame_full = (bit_count == CW'(DATA_WIDTH));
    assign update_ok  = ~strb.test_logic_reset & strb.ir_is_user & strb.update_dr;
    assign push       = update_ok & frame_full;

    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_count <= '0;
        end else if (strb.test_logic_reset) begin
            shift_reg <= '0;
            bit_count <= '0;
        end else if (strb.ir_is_user) begin
            if (strb.capture_dr) begin
                bit_count <= '0;
            end else if (strb.shift_dr) begin
                shift_reg <= {tdi, shift_reg[DATA_WIDTH-1:1]};
                if (!frame_full) bit_count <= bit_count + CW'(1);
            end
        end
    end

    // Sticky flags survive Test-Logic-Reset; only the async reset clears them.
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            overflow    <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            if (push && fifo_full && !(valid && ready)) overflow <= 1'b1;
            if (update_ok && !frame_full) short_frame <= 1'b1;
        end
    end

    tap_rx_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .tck      (tck),
        .reset    (reset),
        .push     (push),
        .push_data(shift_reg),
        .full     (fifo_full),
        .data     (data),
        .valid    (valid),
        .ready    (ready)
    );

endmodule
